// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Indexed [row][col]
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic one_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    case (r)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column strober with press/release debounce; one key_valid per press.
// Press latency 2 + DEBOUNCE_CYCLES + 1 cycles from the row sampling low; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DWELL      = 4800,
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  state_t        state;
  logic [3:0]    row_s;
  logic [3:0]    row_pat;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [1:0]    col_next;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] db_cnt;
  logic          row_up;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (row_s)
  );

  assign col_next = col_idx + 2'd1;
  assign row_up   = row_s[row_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      row_idx   <= 2'd0;
      row_pat   <= 4'b1111;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (one_low(row_s)) begin
              row_idx <= low_index(row_s);
              row_pat <= row_s;
              db_cnt  <= '0;
              state   <= DB_PRESS;
            end else begin
              col_idx <= col_next;
              col_n   <= COL_DRIVE[col_next];
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DB_PRESS: begin
          // Any deviation from the latched pattern restarts scanning on this column
          if (row_s != row_pat) begin
            dwell_cnt <= '0;
            state     <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            key_code  <= KEY_MAP[row_idx][col_idx];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (row_up) begin
            db_cnt <= '0;
            state  <= DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (!row_up) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            key_held  <= 1'b0;
            col_idx   <= col_next;
            col_n     <= COL_DRIVE[col_next];
            dwell_cnt <= '0;
            state     <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model driving row_n from col_n.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;   // bit r*4+c

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int vcons = 0;
  logic prev_valid = 1'b0;
  logic [3:0] exp_col [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scanner #(.SCAN_DWELL(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (!reset && key_valid) pulse_cnt++;
    if (key_valid && prev_valid) vcons++;
    prev_valid = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_pulse(input int max, output logic ok, output int waited);
    int start;
    start = pulse_cnt;
    ok = 1'b0;
    waited = 0;
    while (waited < max && !ok) begin
      @(negedge clk);
      waited++;
      if (pulse_cnt != start) ok = 1'b1;
    end
  endtask

  task automatic wait_release(input int max, output logic ok, output int waited);
    ok = 1'b0;
    waited = 0;
    while (waited < max && !ok) begin
      @(negedge clk);
      waited++;
      if (!key_held) ok = 1'b1;
    end
  endtask

  initial begin
    logic ok;
    int   n;
    int   base;
    logic held_ok;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col", col_n, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);

    // Idle column walk, 4 cycles per column
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("walk_col_%0d", i), col_n, exp_col[(i / 4) % 4]);
      @(negedge clk);
    end
    check("walk_no_pulse", pulse_cnt, 0);

    // Key 6: row 1, col 2
    pressed[6] = 1'b1;
    wait_pulse(200, ok, n);
    check("k6_timeout", ok, 1'b1);
    check("k6_code", key_code, 4'h6);
    check("k6_held", key_held, 1'b1);
    check("k6_col", col_n, 4'b1011);
    repeat (30) @(negedge clk);
    check("k6_single", pulse_cnt, 1);
    check("k6_col_frozen", col_n, 4'b1011);
    pressed[6] = 1'b0;
    wait_release(50, ok, n);
    check("k6_rel_latency", n, 11);
    check("k6_col_adv", col_n, 4'b0111);

    // Key 0 with bounce: row 3, col 1
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      pressed[13] = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_no_pulse", pulse_cnt, base);
    pressed[13] = 1'b1;
    wait_pulse(200, ok, n);
    check("k0_timeout", ok, 1'b1);
    check("k0_wait_min", (n >= 11), 1'b1);
    check("k0_code", key_code, 4'h0);
    pressed[13] = 1'b0;
    wait_release(50, ok, n);
    check("k0_release", ok, 1'b1);

    // Key 1 held, then row 2 also pressed on the same column
    base = pulse_cnt;
    pressed[0] = 1'b1;
    wait_pulse(200, ok, n);
    check("k1_timeout", ok, 1'b1);
    check("k1_code", key_code, 4'h1);
    pressed[8] = 1'b1;
    repeat (30) @(negedge clk);
    check("k1_no_second", pulse_cnt, base + 1);
    check("k1_code_kept", key_code, 4'h1);
    check("k1_held", key_held, 1'b1);
    pressed[8] = 1'b0;
    repeat (5) @(negedge clk);

    // Release with a short low glitch inside the release window
    held_ok = 1'b1;
    pressed[0] = 1'b0;
    repeat (4) begin @(negedge clk); held_ok &= key_held; end
    pressed[0] = 1'b1;
    repeat (3) begin @(negedge clk); held_ok &= key_held; end
    pressed[0] = 1'b0;
    check("glitch_held", held_ok, 1'b1);
    wait_release(50, ok, n);
    check("glitch_release", ok, 1'b1);
    check("glitch_no_pulse", pulse_cnt, base + 1);

    // Reset in the middle of a press debounce
    base = pulse_cnt;
    pressed[3] = 1'b1;
    n = 0;
    while (n < 100 && dut.state != DB_PRESS) begin
      @(negedge clk);
      n++;
    end
    check("dbp_reached", (dut.state == DB_PRESS), 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_col", col_n, 4'b1110);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_valid", key_valid, 1'b0);
    pressed[3] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_rst_no_pulse", pulse_cnt, base);
    check("valid_consec", vcons, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
